// File: rtl/main_mem_responder.sv
// Line-granular backing-store responder: one request at a time, fixed LATENCY, then read line or write echo.
// Optional bounds checking of the line index is compiled in with MAIN_MEM_BOUNDS_CHECK_EN.
module main_mem_responder #(
    parameter int LINE_WORDS  = 4,
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [31:0]             req_addr,
    input  logic [32*LINE_WORDS-1:0] req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [32*LINE_WORDS-1:0] resp_data,
    output logic                    resp_err
);

    localparam int LINE_W      = 32 * LINE_WORDS;
    localparam int OFFSET_BITS = $clog2(LINE_WORDS * 4);
    localparam int IDX_W       = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
    localparam int CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] resp_data_q, resp_data_d;
    logic              mem_we;

    logic [LINE_W-1:0] mem_q [DEPTH_LINES];

    logic [31:0]       line_addr;
    logic [IDX_W-1:0]  req_idx;

    assign line_addr = req_addr >> OFFSET_BITS;
    assign req_idx   = (DEPTH_LINES > 1) ? line_addr[IDX_W-1:0] : '0;

`ifdef MAIN_MEM_BOUNDS_CHECK_EN
    logic req_oob;
    logic oob_q, oob_d;
    logic resp_err_q, resp_err_d;

    // Compare the whole line number so addresses beyond the array are flagged, not aliased.
    assign req_oob  = (line_addr >= 32'(DEPTH_LINES));
    assign resp_err = resp_err_q;
`else
    logic unused_addr_bits;

    assign unused_addr_bits = ^line_addr[31:IDX_W];
    assign resp_err         = 1'b0;
`endif

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_data  = resp_data_q;

    // NOTE: every variable assigned below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        mem_we      = 1'b0;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
        oob_d       = oob_q;
        resp_err_d  = resp_err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    idx_d   = req_idx;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_WAIT;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
                    oob_d   = req_oob;
`endif
                end
            end

            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
                    if (oob_q) begin
                        resp_data_d = '0;
                        resp_err_d  = 1'b1;
                    end else begin
                        resp_err_d = 1'b0;
                        if (we_q) begin
                            mem_we      = 1'b1;
                            resp_data_d = wdata_q;
                        end else begin
                            resp_data_d = mem_q[idx_q];
                        end
                    end
`else
                    if (we_q) begin
                        mem_we      = 1'b1;
                        resp_data_d = wdata_q;
                    end else begin
                        resp_data_d = mem_q[idx_q];
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
        end
    end

`ifdef MAIN_MEM_BOUNDS_CHECK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            oob_q      <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            oob_q      <= oob_d;
            resp_err_q <= resp_err_d;
        end
    end
`endif

    // NOTE: the storage array is deliberately not reset; it maps onto plain RAM and starts unknown.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench for main_mem_responder: default instance plus a LATENCY=1 instance.
module tb_main_mem_responder;

    localparam int LAT = 8;

    typedef struct {
        logic [127:0] data;
        logic         err;
    } exp_t;

    logic         clock;
    logic         reset;
    logic         req_valid, req_ready, req_we;
    logic [31:0]  req_addr;
    logic [127:0] req_wdata;
    logic         resp_valid, resp_ready, resp_err;
    logic [127:0] resp_data;

    logic         l1_req_valid, l1_req_ready, l1_req_we;
    logic [31:0]  l1_req_addr;
    logic [31:0]  l1_req_wdata;
    logic         l1_resp_valid, l1_resp_ready, l1_resp_err;
    logic [31:0]  l1_resp_data;

    int vec_cnt = 0;
    int err_cnt = 0;
    int edge_n = 0;
    int last_accept = 0;
    int accept_count = 0;

    exp_t         sb_q[$];
    exp_t         mon_exp;
    logic [127:0] model [int];

    main_mem_responder u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    main_mem_responder #(.LINE_WORDS(1), .DEPTH_LINES(4), .LATENCY(1)) u_dut_l1 (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (l1_req_valid),
        .req_ready  (l1_req_ready),
        .req_we     (l1_req_we),
        .req_addr   (l1_req_addr),
        .req_wdata  (l1_req_wdata),
        .resp_valid (l1_resp_valid),
        .resp_ready (l1_resp_ready),
        .resp_data  (l1_resp_data),
        .resp_err   (l1_resp_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
        $fatal(1, "watchdog expired");
    end

    // Edge counter, accept tracker and response scoreboard checker.
    always @(posedge clock) begin
        edge_n = edge_n + 1;
        if (reset && req_valid && req_ready) begin
            accept_count = accept_count + 1;
            last_accept  = edge_n;
        end
        if (reset && resp_valid && resp_ready) begin
            vec_cnt++;
            if (sb_q.size() == 0) begin
                err_cnt++;
                $display("FAIL resp_unexpected: got data=%h err=%b, expected no response", resp_data, resp_err);
            end else begin
                mon_exp = sb_q.pop_front();
                if (resp_data !== mon_exp.data || resp_err !== mon_exp.err) begin
                    err_cnt++;
                    $display("FAIL resp_data: got data=%h err=%b, expected data=%h err=%b",
                             resp_data, resp_err, mon_exp.data, mon_exp.err);
                end
            end
        end
    end

    function automatic exp_t predict(input logic we, input logic [31:0] addr, input logic [127:0] wd);
        exp_t e;
        logic [31:0] full;
        int idx;
        full = addr >> 4;
        idx  = int'(full % 256);
`ifdef MAIN_MEM_BOUNDS_CHECK_EN
        if (full >= 256) begin
            e.data = '0;
            e.err  = 1'b1;
            return e;
        end
`endif
        e.err = 1'b0;
        if (we) begin
            model[idx] = wd;
            e.data     = wd;
        end else begin
            e.data = model.exists(idx) ? model[idx] : 'x;
        end
        return e;
    endfunction

    // Present one request; returns at the negedge after it was accepted.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [127:0] wd);
        int n;
        n = 0;
        @(negedge clock);
        while (req_ready !== 1'b1 && n < 64) begin
            @(negedge clock);
            n++;
        end
        vec_cnt++;
        if (req_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL issue_ready: req_ready=%b, expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        sb_q.push_back(predict(we, addr, wd));
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    // Wait for the response, check latency, optionally stall, then complete the handshake.
    task automatic finish_resp(input int hold);
        int n;
        int acc0;
        logic [127:0] d0;
        n = 0;
        while (resp_valid !== 1'b1 && n < 64) begin
            @(negedge clock);
            n++;
        end
        vec_cnt++;
        if (resp_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL resp_timeout: resp_valid=%b, expected 1 within 64 cycles", resp_valid);
            return;
        end
        vec_cnt++;
        if (edge_n - last_accept != LAT) begin
            err_cnt++;
            $display("FAIL resp_latency: got %0d cycles, expected %0d", edge_n - last_accept, LAT);
        end
        vec_cnt++;
        if (req_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL ready_in_resp: req_ready=%b, expected 0", req_ready);
        end
        d0   = resp_data;
        acc0 = accept_count;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            @(negedge clock);
            vec_cnt++;
            if (resp_valid !== 1'b1 || resp_data !== d0) begin
                err_cnt++;
                $display("FAIL resp_stall: valid=%b data=%h, expected valid=1 data=%h", resp_valid, resp_data, d0);
            end
        end
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        vec_cnt++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || accept_count != acc0) begin
            err_cnt++;
            $display("FAIL resp_complete: valid=%b ready=%b accepts=%0d, expected 0 1 %0d",
                     resp_valid, req_ready, accept_count, acc0);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        vec_cnt++;
        if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_req_ready: got %b, expected 1", req_ready); end
        vec_cnt++;
        if (resp_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_resp_valid: got %b, expected 0", resp_valid); end
        vec_cnt++;
        if (resp_data !== 128'h0) begin err_cnt++; $display("FAIL reset_resp_data: got %h, expected 0", resp_data); end
        vec_cnt++;
        if (resp_err !== 1'b0) begin err_cnt++; $display("FAIL reset_resp_err: got %b, expected 0", resp_err); end
        reset = 1'b1;
    endtask

    task automatic test_write_read;
        issue(1'b1, 32'h0000_0040, 128'h00000044_00000033_00000022_00000011);
        finish_resp(0);
        issue(1'b0, 32'h0000_0040, '0);
        finish_resp(0);
        issue(1'b1, 32'h0000_0000, 128'hA5A5A5A5_5A5A5A5A_FFFFFFFF_00000000);
        finish_resp(0);
        issue(1'b1, 32'h0000_0FF0, 128'h0BADF00D_12345678_9ABCDEF0_CAFEBABE);
        finish_resp(0);
        issue(1'b0, 32'h0000_0000, '0);
        finish_resp(0);
        issue(1'b0, 32'h0000_0FFC, '0);
        finish_resp(0);
    endtask

    task automatic test_back_to_back;
        int start, a1, busy, n;
        @(negedge clock);
        start      = accept_count;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h0000_0040;
        resp_ready = 1'b1;
        sb_q.push_back(predict(1'b0, 32'h0000_0040, '0));
        sb_q.push_back(predict(1'b0, 32'h0000_0040, '0));
        busy = 0;
        a1   = 0;
        n    = 0;
        while (accept_count < start + 2 && n < 100) begin
            @(negedge clock);
            n++;
            if (accept_count == start + 1) begin
                if (a1 == 0) a1 = last_accept;
                if (req_ready === 1'b0) busy++;
            end
        end
        req_valid = 1'b0;
        vec_cnt++;
        if (accept_count != start + 2) begin
            err_cnt++;
            $display("FAIL b2b_accepts: got %0d, expected %0d", accept_count - start, 2);
        end
        vec_cnt++;
        if (last_accept - a1 != LAT + 2) begin
            err_cnt++;
            $display("FAIL b2b_spacing: got %0d cycles, expected %0d", last_accept - a1, LAT + 2);
        end
        vec_cnt++;
        if (busy != LAT + 1) begin
            err_cnt++;
            $display("FAIL b2b_busy: req_ready low for %0d cycles, expected %0d", busy, LAT + 1);
        end
        n = 0;
        while (sb_q.size() != 0 && n < 64) begin
            @(negedge clock);
            n++;
        end
        resp_ready = 1'b0;
        vec_cnt++;
        if (sb_q.size() != 0) begin
            err_cnt++;
            $display("FAIL b2b_drain: %0d responses outstanding, expected 0", sb_q.size());
        end
    endtask

    task automatic test_backpressure;
        issue(1'b1, 32'h0000_0080, 128'h11112222_33334444_55556666_77778888);
        finish_resp(5);
        issue(1'b0, 32'h0000_0080, '0);
        finish_resp(5);
    endtask

    task automatic test_reset_mid_op;
        logic [127:0] old;
        int n;
        old = model[4];
        issue(1'b1, 32'h0000_0040, {4{32'hDEAD_BEEF}});
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        vec_cnt++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_wait: valid=%b ready=%b, expected 0 1", resp_valid, req_ready);
        end
        vec_cnt++;
        if (resp_data !== 128'h0) begin
            err_cnt++;
            $display("FAIL reset_wait_data: got %h, expected 0", resp_data);
        end
        void'(sb_q.pop_back());
        model[4] = old;
        @(negedge clock);
        reset = 1'b1;
        issue(1'b0, 32'h0000_0040, '0);
        finish_resp(0);

        issue(1'b0, 32'h0000_0040, '0);
        n = 0;
        while (resp_valid !== 1'b1 && n < 64) begin
            @(negedge clock);
            n++;
        end
        #2 reset = 1'b0;
        #1;
        vec_cnt++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_resp: valid=%b ready=%b, expected 0 1", resp_valid, req_ready);
        end
        void'(sb_q.pop_back());
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_wrap;
        issue(1'b0, 32'h0000_1040, '0);
        finish_resp(0);
        issue(1'b1, 32'h0000_1040, 128'hFEEDFACE_C0FFEE00_01020304_A0B0C0D0);
        finish_resp(0);
        issue(1'b0, 32'h0000_0040, '0);
        finish_resp(0);
    endtask

    task automatic test_latency1;
        @(negedge clock);
        l1_req_valid = 1'b1;
        l1_req_we    = 1'b1;
        l1_req_addr  = 32'h0000_0008;
        l1_req_wdata = 32'hCAFE_F00D;
        @(negedge clock);
        l1_req_valid = 1'b0;
        vec_cnt++;
        if (l1_resp_valid !== 1'b0 || l1_req_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL l1_wait: valid=%b ready=%b, expected 0 0", l1_resp_valid, l1_req_ready);
        end
        @(negedge clock);
        vec_cnt++;
        if (l1_resp_valid !== 1'b1 || l1_resp_data !== 32'hCAFE_F00D) begin
            err_cnt++;
            $display("FAIL l1_write_resp: valid=%b data=%h, expected 1 cafef00d", l1_resp_valid, l1_resp_data);
        end
        l1_resp_ready = 1'b1;
        @(negedge clock);
        l1_resp_ready = 1'b0;
        l1_req_valid  = 1'b1;
        l1_req_we     = 1'b0;
        @(negedge clock);
        l1_req_valid = 1'b0;
        @(negedge clock);
        vec_cnt++;
        if (l1_resp_valid !== 1'b1 || l1_resp_data !== 32'hCAFE_F00D || l1_resp_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL l1_read_resp: valid=%b data=%h err=%b, expected 1 cafef00d 0",
                     l1_resp_valid, l1_resp_data, l1_resp_err);
        end
        l1_resp_ready = 1'b1;
        @(negedge clock);
        l1_resp_ready = 1'b0;
        vec_cnt++;
        if (l1_resp_valid !== 1'b0 || l1_req_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL l1_complete: valid=%b ready=%b, expected 0 1", l1_resp_valid, l1_req_ready);
        end
    endtask

    initial begin
        reset         = 1'b0;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        resp_ready    = 1'b0;
        l1_req_valid  = 1'b0;
        l1_req_we     = 1'b0;
        l1_req_addr   = '0;
        l1_req_wdata  = '0;
        l1_resp_ready = 1'b0;

        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        test_wrap();
        test_latency1();

        repeat (2) @(negedge clock);
        vec_cnt++;
        if (sb_q.size() != 0) begin
            err_cnt++;
            $display("FAIL scoreboard_empty: %0d responses outstanding, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
